store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: a FIFO of pending stores that drains to data memory and checks loads against pending stores.
// Optional macro STORE_BUF_FWD_EN enables store-to-load forwarding of word stores.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [2:0]              st_funct3,
  input  logic                    ld_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    ld_hit,
  output logic [DATA_WIDTH-1:0]   ld_fwd_data,
  output logic                    ld_stall,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [2:0]              mem_funct3,
  input  logic                    mem_busy,
  input  logic                    fence,
  output logic                    fence_done,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            funct3;
  } entry_t;

  entry_t          buf_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic            push, pop, fmt_ok;
  logic            match;
  logic            unused_ld_addr_lo;

  assign fmt_ok    = (st_funct3 == 3'b000) || (st_funct3 == 3'b010);
  assign st_ready  = (count_q < CW'(DEPTH)) && (state_q == RUN);
  assign push      = st_valid && st_ready && fmt_ok;
  assign pop       = (count_q != '0) && !mem_busy;
  assign mem_wr_en = pop;
  assign count     = count_q;
  assign fence_done = (state_q == DONE);
  assign unused_ld_addr_lo = ^ld_addr[1:0];

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_funct3  = '0;
    if (count_q != '0) begin
      mem_addr    = buf_q[rd_ptr_q].addr;
      mem_wr_data = buf_q[rd_ptr_q].data;
      mem_funct3  = buf_q[rd_ptr_q].funct3;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fence) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // NOTE: entry storage has no reset; an entry is only meaningful while the pointers say it is occupied.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
  end

`ifdef STORE_BUF_FWD_EN
  logic                  match_word;
  logic [DATA_WIDTH-1:0] match_data;
`endif

  // Walk oldest to youngest so the last hit left standing is the youngest match.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    match = 1'b0;
`ifdef STORE_BUF_FWD_EN
    match_word = 1'b0;
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (buf_q[idx].addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        match = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_word = (buf_q[idx].funct3 == 3'b010);
        match_data = buf_q[idx].data;
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign ld_hit      = ld_valid && match && match_word;
  assign ld_fwd_data = ld_hit ? match_data : '0;
  assign ld_stall    = ld_valid && match && !match_word;
`else
  assign ld_hit      = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_stall    = ld_valid && match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0, st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [2:0]    st_funct3 = '0;
  logic          ld_valid = 1'b0, ld_hit, ld_stall;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_fwd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [2:0]    mem_funct3;
  logic          mem_busy = 1'b0;
  logic          fence = 1'b0, fence_done;
  logic [2:0]    count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
    .ld_stall(ld_stall),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_funct3(mem_funct3), .mem_busy(mem_busy),
    .fence(fence), .fence_done(fence_done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    f3;
  } ent_t;

  ent_t q[$];
  int   mode = 0;   // 0 normal, 1 draining, 2 drain complete
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic          e_hit, e_stall;
    logic [DW-1:0] e_fwd;
    e_hit = 1'b0; e_stall = 1'b0; e_fwd = '0;
    if (ld_valid) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if ((q[k].addr >> 2) == (ld_addr >> 2)) begin
`ifdef STORE_BUF_FWD_EN
          if (q[k].f3 == 3'b010) begin e_hit = 1'b1; e_fwd = q[k].data; end
          else e_stall = 1'b1;
`else
          e_stall = 1'b1;
`endif
          break;
        end
      end
    end
    check("count",      64'(count),      64'(q.size()));
    check("st_ready",   64'(st_ready),   64'(q.size() < DEPTH && mode == 0));
    check("mem_wr_en",  64'(mem_wr_en),  64'(q.size() != 0 && !mem_busy));
    check("mem_addr",   64'(mem_addr),   q.size() != 0 ? 64'(q[0].addr) : 64'd0);
    check("mem_data",   64'(mem_wr_data), q.size() != 0 ? 64'(q[0].data) : 64'd0);
    check("mem_funct3", 64'(mem_funct3), q.size() != 0 ? 64'(q[0].f3) : 64'd0);
    check("fence_done", 64'(fence_done), 64'(mode == 2));
    check("ld_hit",     64'(ld_hit),     64'(e_hit));
    check("ld_fwd",     64'(ld_fwd_data), 64'(e_fwd));
    check("ld_stall",   64'(ld_stall),   64'(e_stall));
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [2:0] f3, input logic busy, input logic fen,
                       input logic lv, input logic [AW-1:0] la);
    st_valid = sv; st_addr = a; st_data = d; st_funct3 = f3;
    mem_busy = busy; fence = fen; ld_valid = lv; ld_addr = la;
  endtask

  task automatic idle(input logic busy);
    drive(1'b0, '0, '0, 3'b000, busy, 1'b0, 1'b0, '0);
  endtask

  // Called at a falling edge with inputs already driven; checks, advances the model, crosses one rising edge.
  task automatic step();
    logic ready_m, pop_m, push_m;
    #1;
    check_outputs();
    ready_m = (q.size() < DEPTH) && (mode == 0);
    pop_m   = (q.size() != 0) && !mem_busy;
    push_m  = st_valid && ready_m && (st_funct3 == 3'b000 || st_funct3 == 3'b010);
    case (mode)
      0: if (fence) mode = 1;
      1: if (q.size() == 0) mode = 2;
      default: mode = 0;
    endcase
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back('{addr: st_addr, data: st_data, f3: st_funct3});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single word store drains the next cycle.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0, 1'b0, '0);
    step();
    idle(1'b0);
    check("wr_en_after_1", 64'(mem_wr_en), 64'd1);
    check("wr_addr_0x10", 64'(mem_addr), 64'h10);
    step();
    step();

    // Memory busy: fifth store refused, then FIFO-order drain; an unsupported funct3 is dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(32'h100 + 4 * i), DW'(32'hA000 + i), 3'b010, 1'b1, 1'b0, 1'b0, '0);
      step();
    end
    check("full_count", 64'(count), 64'd4);
    // Full with memory free: pop happens but no push in the same cycle.
    drive(1'b1, 32'h200, 32'hBAD, 3'b010, 1'b0, 1'b0, 1'b0, '0);
    step();
    check("after_full_pop", 64'(count), 64'd3);
    idle(1'b0);
    repeat (4) step();
    drive(1'b1, 32'h300, 32'h1, 3'b001, 1'b0, 1'b0, 1'b0, '0);
    step();
    idle(1'b0);
    step();

    // Two word stores then a byte store to the same word; load checks in between.
    drive(1'b1, 32'h20, 32'h11111111, 3'b010, 1'b1, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h20, 32'h22222222, 3'b010, 1'b1, 1'b0, 1'b1, 32'h22); step();
    drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h22); step();
    drive(1'b1, 32'h23, 32'h000000AB, 3'b000, 1'b1, 1'b0, 1'b1, 32'h22); step();
    drive(1'b0, '0, '0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h20); step();
    drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h20);
    repeat (4) step();

    // Fence with three pending stores, then fence on an empty buffer.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h40 + 4 * i), DW'(32'hF0 + i), 3'b010, 1'b1, 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b1, 32'h80, 32'h5, 3'b010, 1'b1, 1'b1, 1'b0, '0); step();
    drive(1'b1, 32'h84, 32'h6, 3'b010, 1'b0, 1'b0, 1'b0, '0);
    repeat (7) step();
    drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b1, 1'b0, '0); step();
    idle(1'b0);
    repeat (4) step();

    // Asynchronous reset with two entries pending.
    drive(1'b1, 32'h50, 32'h7, 3'b010, 1'b1, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h54, 32'h8, 3'b010, 1'b1, 1'b0, 1'b0, '0); step();
    idle(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_ready", 64'(st_ready), 64'd1);
    q.delete();
    mode = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) < 6) ? ($urandom_range(0, 1) ? 3'b010 : 3'b000)
                                       : 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom), f3,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
